pipeline_skid_reg: RTL

- Full valid/ready register slice. Registers both the forward path (out_valid, out_data) and the backward path (in_ready), so no combinational path runs from out_ready to in_ready.
- A 2-entry buffer (main + skid) absorbs the one word in flight when downstream stalls.
- Drops between pipeline stages on long or timing-critical ready chains. Same handshake semantics as the forward-only pipeline register.

---
 rtl/pipeline_skid_reg.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pipeline_skid_reg.sv
// -----------------------------------------------------------------------------
// pipeline_skid_reg
//
// Full valid/ready register slice. Both the forward path (out_valid, out_data)
// and the backward path (in_ready) come straight from flops, so there is no
// combinational path from out_ready to in_ready. A two-entry buffer (main +
// skid) absorbs the word already in flight when downstream stalls.
//
// Optional feature macro: SKID_STATS_EN
//   When defined, the CNT_WIDTH parameter and the stall_cnt/occupancy ports
//   exist. When undefined, they are absent and the datapath is unchanged.
//
// Parameters
//   DATA_WIDTH  payload width in bits
//   CNT_WIDTH   stall counter width (SKID_STATS_EN only)
//
// Ports
//   clk        single clock, all logic on the rising edge
//   reset      synchronous, active-high
//   in_valid   upstream word valid (ignored while in_ready = 0)
//   in_ready   registered; block can accept a word this cycle
//   in_data    upstream payload
//   out_valid  registered; main entry holds a valid word
//   out_ready  downstream accepts
//   out_data   registered payload from the main entry
//   stall_cnt  saturating count of cycles with out_valid & !out_ready
//   occupancy  entries held: 0 / 1 / 2
// -----------------------------------------------------------------------------
module pipeline_skid_reg #(
  parameter int unsigned DATA_WIDTH = 32
`ifdef SKID_STATS_EN
  , parameter int unsigned CNT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef SKID_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [1:0]            occupancy
`endif
);

  // Encoding equals the number of entries held, so occupancy is the state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;

  logic acc;
  logic con;

  assign acc = in_valid & in_ready_q;
  assign con = out_valid_q & out_ready;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          main_d  = in_data;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (acc && con) begin
          main_d = in_data;          // full throughput: replace as it leaves
        end else if (acc) begin
          skid_d  = in_data;         // word in flight while downstream stalls
          state_d = ST_FULL;
        end else if (con) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so acc cannot occur.
        if (con) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Both handshake outputs are computed from the next state and registered.
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order. The two data
  // entries are reset as well, since out_data must read zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

`ifdef SKID_STATS_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign occupancy = state_q;
`endif

endmodule
